// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Credit-limited requests to instruction
//            memory, response FIFO towards decode, branch redirect and halt.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt_in,
    output logic        halted
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [63:0]      resp_pc_q, resp_pc_d;
    logic [31:0]      fifo_inst_q [DEPTH];
    logic [31:0]      fifo_inst_d [DEPTH];
    logic [63:0]      fifo_pc_q [DEPTH];
    logic [63:0]      fifo_pc_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             halted_q, halted_d;

    logic [CNT_W:0]   w_used;
    logic             w_empty;
    logic             w_full;
    logic             w_grant;
    logic             w_push;
    logic             w_pop;
    logic [63:0]      w_redir_pc;
    logic             w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    always_comb begin
        w_used     = {1'b0, count_q} + {1'b0, outstanding_q};
        w_empty    = (count_q == '0);
        w_full     = (count_q == C_DEPTH);
        // Buffered plus in-flight words may never exceed the FIFO depth.
        imem_req   = !reset && !halt_in && !redirect_valid && (w_used < {1'b0, C_DEPTH});
        w_grant    = imem_req && imem_gnt;
        w_pop      = !w_empty && inst_ready && !redirect_valid;
        w_push     = imem_rvalid && (drop_cnt_q == '0) && !redirect_valid;
        w_redir_pc = {redirect_pc[63:2], 2'b00};

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        fifo_inst_d   = fifo_inst_q;
        fifo_pc_d     = fifo_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CNT_W'(w_grant) - CNT_W'(imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        halted_d      = halt_in && (outstanding_q == '0);

        if (redirect_valid) begin
            fetch_pc_d = w_redir_pc;
            resp_pc_d  = w_redir_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A response arriving in the redirect cycle is already discarded.
            drop_cnt_d = outstanding_q - CNT_W'(imem_rvalid);
        end else begin
            if (w_grant) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (w_push) begin
                fifo_inst_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                resp_pc_d             = resp_pc_q + 64'd4;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            halted_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            halted_q      <= halted_d;
            fifo_inst_q   <= fifo_inst_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = !w_empty;
    assign inst       = fifo_inst_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
    assign halted     = halted_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit with a small
//            in-order instruction memory model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt_in;
    logic        halted;

    bit          mem_en;
    logic [63:0] mq [$];
    int          n_grants = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(64'h0),
        .DEPTH   (2)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_in       (halt_in),
        .halted        (halted)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample the handshake, cross the edge, advance the memory model.
    task automatic step();
        logic        g;
        logic        c;
        logic [63:0] a;
        #1;
        g = imem_req && imem_gnt;
        c = imem_rvalid;
        a = imem_addr;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
        end else begin
            if (c && (mq.size() != 0)) mq.delete(0);
            if (g) begin
                mq.push_back(a);
                n_grants++;
            end
        end
        imem_rvalid = mem_en && (mq.size() != 0);
        imem_rdata  = (mq.size() != 0) ? mem_word(mq[0]) : 32'h0;
        #1;
    endtask

    task automatic reset_dut();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        halt_in        = 1'b0;
        inst_ready     = 1'b0;
        imem_gnt       = 1'b1;
        mem_en         = 1'b1;
        step();
        step();
        reset    = 1'b0;
        n_grants = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
        halt_in = 1'b0; mem_en = 1'b1;

        // Reset values
        step();
        step();
        check("rst_req",   imem_req,   64'd0);
        check("rst_valid", inst_valid, 64'd0);
        check("rst_halt",  halted,     64'd0);
        check("rst_inst",  inst,       64'd0);
        check("rst_pc",    inst_pc,    64'd0);
        check("rst_addr",  imem_addr,  64'd0);

        // Streaming
        reset = 1'b0; inst_ready = 1'b1; n_grants = 0;
        #1;
        check("str_req0",  imem_req,  64'd1);
        check("str_addr0", imem_addr, 64'd0);
        step();
        check("str_nv1",   inst_valid, 64'd0);
        check("str_addr1", imem_addr,  64'd4);
        step();
        check("str_v2",    inst_valid, 64'd1);
        check("str_nocred", imem_req,  64'd0);
        exp_pc = 64'd0;
        for (int cyc = 0; cyc < 16 && exp_pc < 64'd16; cyc++) begin
            if (inst_valid) begin
                check("str_pc",   inst_pc, exp_pc);
                check("str_data", inst,    mem_word(exp_pc));
                exp_pc = exp_pc + 64'd4;
            end
            step();
        end
        check("str_delivered", exp_pc, 64'd16);

        // Backpressure
        reset_dut();
        inst_ready = 1'b0;
        repeat (5) step();
        check("bp_grants", n_grants,   64'd2);
        check("bp_req",    imem_req,   64'd0);
        check("bp_valid",  inst_valid, 64'd1);
        check("bp_pc",     inst_pc,    64'd0);
        check("bp_data",   inst,       mem_word(64'd0));
        step();
        check("bp_pc_stable", inst_pc, 64'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #1;
        check("bp_pc_next",   inst_pc,   64'd4);
        check("bp_req_again", imem_req,  64'd1);
        check("bp_addr",      imem_addr, 64'd8);

        // Redirect with two requests in flight
        reset_dut();
        inst_ready = 1'b1; mem_en = 1'b0;
        step();
        step();
        check("rd_req_full", imem_req, 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h1003; mem_en = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rd_addr", imem_addr, 64'h1000);
        step();
        check("rd_drop1", inst_valid, 64'd0);
        step();
        check("rd_drop2", inst_valid, 64'd0);
        step();
        check("rd_valid", inst_valid, 64'd1);
        check("rd_pc",    inst_pc,    64'h1000);
        check("rd_data",  inst,       mem_word(64'h1000));

        // Redirect coinciding with a response and a pop
        reset_dut();
        mem_en = 1'b0;
        step();
        step();
        mem_en = 1'b1;
        step();
        step();
        check("rc_valid_pre", inst_valid,  64'd1);
        check("rc_rvalid",    imem_rvalid, 64'd1);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h2000;
        step();
        redirect_valid = 1'b0;
        #1;
        check("rc_flushed", inst_valid, 64'd0);
        check("rc_req",     imem_req,   64'd1);
        check("rc_addr",    imem_addr,  64'h2000);
        step();
        step();
        check("rc_valid", inst_valid, 64'd1);
        check("rc_pc",    inst_pc,    64'h2000);
        check("rc_data",  inst,       mem_word(64'h2000));

        // Halt with one request outstanding
        reset_dut();
        inst_ready = 1'b1; mem_en = 1'b0;
        step();
        halt_in = 1'b1; mem_en = 1'b1;
        #1;
        check("h_req_blocked", imem_req, 64'd0);
        step();
        check("h_not_halted", halted, 64'd0);
        step();
        check("h_valid", inst_valid, 64'd1);
        check("h_pc",    inst_pc,    64'd0);
        step();
        check("h_halted", halted, 64'd1);
        halt_in = 1'b0;
        #1;
        check("h_resume_req",  imem_req,  64'd1);
        check("h_resume_addr", imem_addr, 64'd4);
        step();
        check("h_unhalted", halted, 64'd0);

        // PC wrap, then reset mid-stream
        reset_dut();
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("w_req_redir", imem_req, 64'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("w_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("w_addr_wrap", imem_addr, 64'd0);
        step();
        check("w_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("w_pc_wrap", inst_pc, 64'd0);
        reset = 1'b1;
        step();
        check("mr_req",   imem_req,   64'd0);
        check("mr_valid", inst_valid, 64'd0);
        check("mr_halt",  halted,     64'd0);
        check("mr_inst",  inst,       64'd0);
        check("mr_pc",    inst_pc,    64'd0);
        check("mr_addr",  imem_addr,  64'd0);
        reset = 1'b0;
        #1;
        check("mr_req_after",  imem_req,  64'd1);
        check("mr_addr_after", imem_addr, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
